// File: rtl/bitrev_addr_gen.sv
// Bit-reversed address generator with valid/ready output handshake.
// Produces base + R(c) for c = 0..N-1, where R reverses the low log_n bits of c
// (or bits [log_n:1] with bit 0 passed through when keep_lsb is set).
// Optional macro BITREV_REPEAT_EN adds repeat_i: the sequence wraps instead of
// finishing, and abort_i becomes the only exit.
module bitrev_addr_gen #(
    parameter int ADDR_W  = 16,
    parameter int MAX_LOG = 14
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [3:0]        log_n_i,
    input  logic              keep_lsb_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic              abort_i,
    input  logic              addr_ready_i,
`ifdef BITREV_REPEAT_EN
    input  logic              repeat_i,
`endif
    output logic [ADDR_W-1:0] addr_o,
    output logic              addr_valid_o,
    output logic              last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    // Counter holds one extra bit so keep_lsb with log_n=MAX_LOG still fits.
    localparam int CW = MAX_LOG + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [3:0]        log_n_q;
    logic              keep_q;
    logic [ADDR_W-1:0] base_q;
    logic              rep_done_q;
    logic              rep;
    logic              cfg_ok;
    logic              take_start;
    logic              advance;
    logic              at_last;
    logic [CW-1:0]     cnt_nxt;

`ifdef BITREV_REPEAT_EN
    assign rep = repeat_i;
`else
    assign rep = 1'b0;
`endif

    // Reverse the low ln bits of the field; bits above the field are zero.
    function automatic logic [CW-1:0] bit_rev(input logic [CW-1:0] c,
                                              input logic [3:0]    ln,
                                              input logic          keep);
        logic [CW-1:0] f;
        logic [CW-1:0] r;
        f = keep ? (c >> 1) : c;
        r = '0;
        for (int i = 0; i < CW; i++) begin
            for (int j = 0; j < CW; j++) begin
                if (i + j == int'(ln) - 1) r[i] = f[j];
            end
        end
        return keep ? {r[CW-2:0], c[0]} : r;
    endfunction

    // Final count N-1 = 2^(ln+keep)-1, evaluated modulo 2^CW so the widest case wraps to all-ones.
    function automatic logic [CW-1:0] last_count(input logic [3:0] ln, input logic keep);
        logic [CW-1:0] one;
        one = CW'(1);
        return (one << (int'(ln) + int'(keep))) - one;
    endfunction

    assign cfg_ok     = (log_n_i != 4'd0) && (int'(log_n_i) <= MAX_LOG);
    assign take_start = (state == IDLE) && start_i && cfg_ok;
    assign at_last    = (cnt == last_count(log_n_q, keep_q));
    assign advance    = (state == RUN) && !abort_i && addr_ready_i;
    assign cnt_nxt    = at_last ? '0 : cnt + CW'(1);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: abort wins over the final handshake; repeat suppresses DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (take_start) state_nxt = RUN;
            RUN: begin
                if (abort_i)                       state_nxt = IDLE;
                else if (advance && at_last && !rep) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Configuration latch on an accepted start.
    always_ff @(posedge clk_i) begin
        if (take_start) begin
            log_n_q <= log_n_i;
            keep_q  <= keep_lsb_i;
            base_q  <= base_i;
        end
    end

    // Counter, registered address and one-cycle status pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt        <= '0;
            addr_o     <= '0;
            err_o      <= 1'b0;
            rep_done_q <= 1'b0;
        end else begin
            err_o      <= (state == IDLE) && start_i && !cfg_ok;
            rep_done_q <= advance && at_last && rep;
            if (take_start) begin
                cnt    <= '0;
                addr_o <= base_i;
            end else if (advance) begin
                cnt    <= cnt_nxt;
                addr_o <= base_q + ADDR_W'(bit_rev(cnt_nxt, log_n_q, keep_q));
            end
        end
    end

    assign addr_valid_o = (state == RUN);
    assign last_o       = (state == RUN) && at_last;
    assign busy_o       = (state != IDLE);
    assign done_o       = (state == DONE) || rep_done_q;

endmodule

// File: tb/tb_bitrev_addr_gen.sv
// Directed testbench for bitrev_addr_gen with hand-computed address sequences.
module tb_bitrev_addr_gen;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic [3:0]  log_n_i = 4'd0;
    logic        keep_lsb_i = 1'b0;
    logic [15:0] base_i = 16'd0;
    logic        abort_i = 1'b0;
    logic        addr_ready_i = 1'b0;
`ifdef BITREV_REPEAT_EN
    logic        repeat_i = 1'b0;
`endif
    logic [15:0] addr_o;
    logic        addr_valid_o, last_o, busy_o, done_o, err_o;

    int n_cmp = 0;
    int n_fail = 0;

    bitrev_addr_gen #(.ADDR_W(16), .MAX_LOG(14)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .log_n_i(log_n_i),
        .keep_lsb_i(keep_lsb_i), .base_i(base_i), .abort_i(abort_i),
        .addr_ready_i(addr_ready_i),
`ifdef BITREV_REPEAT_EN
        .repeat_i(repeat_i),
`endif
        .addr_o(addr_o), .addr_valid_o(addr_valid_o), .last_o(last_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        n_cmp++; if (addr_o !== 16'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0000", addr_o); end
        n_cmp++; if (addr_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", addr_valid_o); end
        n_cmp++; if (last_o !== 1'b0) begin n_fail++; $display("FAIL reset_last got=%b exp=0", last_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err_o); end
    endtask

    task automatic test_basic();
        logic [15:0] exp_a [8] = '{16'd0, 16'd4, 16'd2, 16'd6, 16'd1, 16'd5, 16'd3, 16'd7};
        log_n_i = 4'd3; keep_lsb_i = 1'b0; base_i = 16'h0000; addr_ready_i = 1'b1;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (addr_o !== exp_a[i]) begin n_fail++; $display("FAIL basic_addr[%0d] got=%h exp=%h", i, addr_o, exp_a[i]); end
            n_cmp++; if (addr_valid_o !== 1'b1) begin n_fail++; $display("FAIL basic_valid[%0d] got=%b exp=1", i, addr_valid_o); end
            n_cmp++; if (last_o !== (i == 7)) begin n_fail++; $display("FAIL basic_last[%0d] got=%b exp=%b", i, last_o, (i == 7)); end
            n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL basic_early_done[%0d] got=%b exp=0", i, done_o); end
            step();
        end
        n_cmp++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL basic_done got=%b exp=1", done_o); end
        n_cmp++; if (addr_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_done_valid got=%b exp=0", addr_valid_o); end
        n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL basic_done_busy got=%b exp=1", busy_o); end
        step();
        n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got=%b exp=0", done_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy got=%b exp=0", busy_o); end
    endtask

    task automatic test_keep_lsb();
        logic [15:0] exp_a [8] = '{16'h100, 16'h101, 16'h104, 16'h105, 16'h102, 16'h103, 16'h106, 16'h107};
        log_n_i = 4'd2; keep_lsb_i = 1'b1; base_i = 16'h0100; addr_ready_i = 1'b1;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (addr_o !== exp_a[i]) begin n_fail++; $display("FAIL keep_addr[%0d] got=%h exp=%h", i, addr_o, exp_a[i]); end
            n_cmp++; if (last_o !== (i == 7)) begin n_fail++; $display("FAIL keep_last[%0d] got=%b exp=%b", i, last_o, (i == 7)); end
            step();
        end
        n_cmp++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL keep_done got=%b exp=1", done_o); end
        step();
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_a [8] = '{16'hFFFC, 16'h0000, 16'hFFFE, 16'h0002, 16'hFFFD, 16'h0001, 16'hFFFF, 16'h0003};
        int k = 0;
        int cyc = 0;
        log_n_i = 4'd3; keep_lsb_i = 1'b0; base_i = 16'hFFFC; addr_ready_i = 1'b0;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        while (k < 8 && cyc < 40) begin
            n_cmp++; if (addr_o !== exp_a[k]) begin n_fail++; $display("FAIL bp_addr[%0d] cyc=%0d got=%h exp=%h", k, cyc, addr_o, exp_a[k]); end
            n_cmp++; if (addr_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got=%b exp=1", k, addr_valid_o); end
            n_cmp++; if (last_o !== (k == 7)) begin n_fail++; $display("FAIL bp_last[%0d] got=%b exp=%b", k, last_o, (k == 7)); end
            addr_ready_i = (cyc % 2 == 0);
            step();
            if (addr_ready_i) k++;
            cyc++;
        end
        addr_ready_i = 1'b0;
        n_cmp++; if (k !== 8) begin n_fail++; $display("FAIL bp_handshakes got=%0d exp=8", k); end
        n_cmp++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL bp_done got=%b exp=1", done_o); end
        step();
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL bp_idle_busy got=%b exp=0", busy_o); end
    endtask

    task automatic test_err();
        logic [3:0] bad [2] = '{4'd0, 4'd15};
        for (int i = 0; i < 2; i++) begin
            log_n_i = bad[i]; start_i = 1'b1;
            step();
            start_i = 1'b0;
            n_cmp++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_pulse[%0d] got=%b exp=1", i, err_o); end
            n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL err_busy[%0d] got=%b exp=0", i, busy_o); end
            n_cmp++; if (addr_valid_o !== 1'b0) begin n_fail++; $display("FAIL err_valid[%0d] got=%b exp=0", i, addr_valid_o); end
            step();
            n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL err_width[%0d] got=%b exp=0", i, err_o); end
            n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL err_stay_idle[%0d] got=%b exp=0", i, busy_o); end
        end
    endtask

    task automatic test_abort_and_reset();
        log_n_i = 4'd4; keep_lsb_i = 1'b0; base_i = 16'h0000; addr_ready_i = 1'b1;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        step();
        n_cmp++; if (addr_o !== 16'd4) begin n_fail++; $display("FAIL abort_addr3 got=%h exp=0004", addr_o); end
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        n_cmp++; if (addr_valid_o !== 1'b0) begin n_fail++; $display("FAIL abort_valid got=%b exp=0", addr_valid_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL abort_done got=%b exp=0", done_o); end
        step();
        n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL abort_late_done got=%b exp=0", done_o); end
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        n_cmp++; if (addr_o !== 16'd8) begin n_fail++; $display("FAIL rst_pre_addr got=%h exp=0008", addr_o); end
        rst_i = 1'b1; start_i = 1'b1; abort_i = 1'b1;
        step();
        rst_i = 1'b0; start_i = 1'b0; abort_i = 1'b0;
        n_cmp++; if ({addr_o, addr_valid_o, last_o, busy_o, done_o, err_o} !== 21'd0) begin
            n_fail++; $display("FAIL midrun_reset got=%h/%b%b%b%b%b exp=all zero", addr_o, addr_valid_o, last_o, busy_o, done_o, err_o);
        end
    endtask

    task automatic test_back_to_back();
        log_n_i = 4'd1; keep_lsb_i = 1'b0; base_i = 16'h0010; addr_ready_i = 1'b1;
        start_i = 1'b1;
        step();
        base_i = 16'h0020;
        n_cmp++; if (addr_o !== 16'h0010) begin n_fail++; $display("FAIL b2b_addr0 got=%h exp=0010", addr_o); end
        step();
        n_cmp++; if (addr_o !== 16'h0011) begin n_fail++; $display("FAIL b2b_addr1 got=%h exp=0011", addr_o); end
        n_cmp++; if (last_o !== 1'b1) begin n_fail++; $display("FAIL b2b_last got=%b exp=1", last_o); end
        step();
        n_cmp++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL b2b_done got=%b exp=1", done_o); end
        step();
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL b2b_start_in_done got=%b exp=0", busy_o); end
        step();
        start_i = 1'b0;
        n_cmp++; if (addr_valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_restart_valid got=%b exp=1", addr_valid_o); end
        n_cmp++; if (addr_o !== 16'h0020) begin n_fail++; $display("FAIL b2b_restart_addr got=%h exp=0020", addr_o); end
        step();
        step();
        step();
    endtask

`ifdef BITREV_REPEAT_EN
    task automatic test_repeat();
        log_n_i = 4'd1; keep_lsb_i = 1'b0; base_i = 16'h0000; addr_ready_i = 1'b1; repeat_i = 1'b1;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (addr_o !== 16'(i % 2)) begin n_fail++; $display("FAIL rep_addr[%0d] got=%h exp=%h", i, addr_o, 16'(i % 2)); end
            n_cmp++; if (addr_valid_o !== 1'b1) begin n_fail++; $display("FAIL rep_valid[%0d] got=%b exp=1", i, addr_valid_o); end
            n_cmp++; if (done_o !== (i >= 2 && i % 2 == 0)) begin n_fail++; $display("FAIL rep_done[%0d] got=%b exp=%b", i, done_o, (i >= 2 && i % 2 == 0)); end
            step();
        end
        abort_i = 1'b1;
        step();
        abort_i = 1'b0; repeat_i = 1'b0;
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rep_abort_busy got=%b exp=0", busy_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_keep_lsb();
        test_backpressure();
        test_err();
        test_abort_and_reset();
        test_back_to_back();
`ifdef BITREV_REPEAT_EN
        test_repeat();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bitrev_addr_gen.md
BITREV_ADDR_GEN -- requirements
Module: bitrev_addr_gen

Interface
REQ-001 Parameter ADDR_W, 16, address width in bits.
REQ-002 Parameter MAX_LOG, 14, largest legal log_n_i value; legal range is 1..ADDR_W-1.
REQ-003 clk_i  input  1  single clock; all logic is on the rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 start_i  input  1  request a new sequence; sampled only in IDLE.
REQ-006 log_n_i  input  4  number of bits to reverse; sampled with start_i.
REQ-007 keep_lsb_i  input  1  1 = bit 0 passes through and bits [log_n:1] are reversed; sampled with start_i.
REQ-008 base_i  input  ADDR_W  base address added to every reversed index; sampled with start_i.
REQ-009 abort_i  input  1  terminate the running sequence.
REQ-010 addr_ready_i  input  1  consumer accepts addr_o.
REQ-011 addr_o  output  ADDR_W  current address, registered.
REQ-012 addr_valid_o  output  1  addr_o is valid.
REQ-013 last_o  output  1  addr_o is the final address of the sequence.
REQ-014 busy_o  output  1  FSM is not in IDLE.
REQ-015 done_o  output  1  one-cycle pulse after the final handshake.
REQ-016 err_o  output  1  one-cycle pulse on a start with an illegal configuration.

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-018 In IDLE, start_i=1 with log_n_i in 1..MAX_LOG SHALL latch the configuration, clear the counter c and enter RUN next cycle.
  - Sequence length N = 2^(log_n + keep_lsb).
REQ-019 In IDLE, start_i=1 with log_n_i=0 or log_n_i>MAX_LOG SHALL pulse err_o for one cycle and remain in IDLE.
REQ-020 addr_o SHALL equal (base + R(c)) mod 2^ADDR_W, where R is defined as follows.
  - keep_lsb=0: R reverses c[log_n-1:0].
  - keep_lsb=1: R reverses c[log_n:1] into bits [log_n:1], with R[0]=c[0].
  - All bits of R above the reversed field are 0.
REQ-021 addr_valid_o SHALL be 1 throughout RUN.
  - Latency: the first address (c=0) is valid in the first RUN cycle, one cycle after start_i.
REQ-022 A handshake SHALL be the condition addr_valid_o & addr_ready_i.
  - c increments only on a handshake.
  - addr_o, addr_valid_o and last_o stay stable while addr_ready_i=0.
REQ-023 last_o SHALL be 1 exactly when addr_valid_o=1 and c=N-1.
REQ-024 The handshake at c=N-1 SHALL enter DONE.
  - In DONE, addr_valid_o=0 and done_o=1 for one cycle, then the FSM returns to IDLE.
REQ-025 start_i SHALL be ignored in RUN and DONE.
  - A start_i in the IDLE cycle following DONE is honoured.
REQ-026 abort_i=1 in RUN SHALL return the FSM to IDLE next cycle, with no done_o.
  - abort_i takes priority over a simultaneous handshake.
  - abort_i is ignored in IDLE and DONE.
REQ-027 busy_o SHALL be 1 in RUN and DONE.
REQ-028 The counter width SHALL be MAX_LOG+1 bits, and c SHALL never exceed N-1.

Reset
REQ-029 rst_i=1 SHALL force state IDLE and c=0 at the next edge, including mid-sequence.
REQ-030 Reset values SHALL be: addr_o=0, addr_valid_o=0, last_o=0, busy_o=0, done_o=0, err_o=0.
REQ-031 rst_i SHALL override start_i and abort_i in the same cycle.

Configuration
REQ-032 Macro BITREV_REPEAT_EN SHALL control repeat mode.
  - Defined: an extra input repeat_i (1 bit) is added.
    - If repeat_i=1 at the c=N-1 handshake, c wraps to 0, the FSM stays in RUN and done_o pulses in the following cycle while addr_valid_o stays 1.
    - The pulse aligns with address c=0.
    - abort_i is the only exit.
  - Undefined: repeat_i does not exist, and behaviour equals repeat_i=0.

Verification
REQ-033 log_n=3, keep=0, base=0, ready tied 1 -> addresses 0,4,2,6,1,5,3,7, last_o on 7, done_o one cycle later, busy_o=0 after that.
REQ-034 log_n=2, keep=1, base=0x0100 -> addresses 0x100,0x101,0x104,0x105,0x102,0x103,0x106,0x107.
REQ-035 log_n=3, base=0xFFFC, ready toggling 1,0,1,0 -> addresses 0xFFFC,0x0000,0xFFFE,... with wraparound and held stable during ready=0; exactly 8 handshakes.
REQ-036 start with log_n=0, then with log_n=15 -> err_o pulses twice, busy_o stays 0, addr_valid_o stays 0.
REQ-037 abort_i at the 3rd handshake cycle of log_n=4 -> valid drops next cycle, no done_o; rst_i mid-RUN -> all outputs 0 next cycle.
REQ-038 BITREV_REPEAT_EN defined, repeat_i=1, log_n=1 -> addresses 0,1,0,1,... with done_o pulsing alongside each c=0 after the first pass; abort_i ends the sequence.
